// File: rtl/irq_ctrl.sv
// irq_ctrl: external interrupt controller. Synchronises asynchronous lines,
// latches rising edges as pending, masks them with a per-line enable and
// hands one prioritised request at a time to the core via ack/iret.
module irq_ctrl #(
    parameter int N_IRQ = 31,
    parameter int ID_W  = 5
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [N_IRQ-1:0] i_ext,
    input  logic             i_en_wr,
    input  logic [N_IRQ-1:0] i_en_data,
    output logic [N_IRQ-1:0] o_en,
    output logic [N_IRQ-1:0] o_pending,
    output logic             o_irq,
    output logic [ID_W-1:0]  o_irq_id,
    input  logic             i_irq_ack,
    input  logic             i_iret
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t           state;
    logic [N_IRQ-1:0] sync1, sync2, hist;
    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] eligible;
    logic [N_IRQ-1:0] clr_mask;
    logic             ack_ok;
    logic             any_req;
    logic [ID_W-1:0]  win_id;

    // Edge condition lasts one cycle: synchronised high, history still low.
    assign rise     = sync2 & ~hist;
    assign eligible = o_pending & o_en;
    assign any_req  = |eligible;
    // An ack only counts while a request is outstanding.
    assign ack_ok   = (state == REQ) && i_irq_ack;

    // One-hot clear for the line being accepted.
    always_comb begin
        clr_mask = '0;
        if (ack_ok) clr_mask[o_irq_id] = 1'b1;
    end

    // Lowest index wins: scan downward so the last hit is the smallest.
    always_comb begin
        win_id = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) win_id = ID_W'(i);
        end
    end

    // Two-flop synchroniser plus history flop; history resets low so a line
    // held high through reset release is seen as one edge.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            sync1 <= '0;
            sync2 <= '0;
            hist  <= '0;
        end else begin
            sync1 <= i_ext;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    // Pending set by edges (regardless of mask), cleared by accepted ack;
    // the OR after the clear lets a same-cycle edge win.
    always_ff @(posedge Clk) begin
        if (!Rst) o_pending <= '0;
        else      o_pending <= (o_pending & ~clr_mask) | rise;
    end

    // Enable mask register, all lines enabled out of reset.
    always_ff @(posedge Clk) begin
        if (!Rst)         o_en <= '1;
        else if (i_en_wr) o_en <= i_en_data;
    end

    // Request FSM with registered request/ID; no preemption or withdrawal in REQ.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state    <= IDLE;
            o_irq    <= 1'b0;
            o_irq_id <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        o_irq_id <= win_id;
                        o_irq    <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (i_irq_ack) begin
                        o_irq <= 1'b0;
                        state <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (i_iret) state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    o_irq <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: inputs driven and outputs checked on the
// falling clock edge, expected values hand-derived from the edge pipeline
// (sample -> edge -> pending -> request).
module tb_irq_ctrl;

    localparam int N_IRQ = 31;
    localparam int ID_W  = 5;
    localparam logic [N_IRQ-1:0] ALL = '1;

    logic             Clk = 1'b0;
    logic             Rst;
    logic [N_IRQ-1:0] i_ext;
    logic             i_en_wr;
    logic [N_IRQ-1:0] i_en_data;
    logic [N_IRQ-1:0] o_en;
    logic [N_IRQ-1:0] o_pending;
    logic             o_irq;
    logic [ID_W-1:0]  o_irq_id;
    logic             i_irq_ack;
    logic             i_iret;

    int ntests = 0;
    int nfail  = 0;

    irq_ctrl #(.N_IRQ(N_IRQ), .ID_W(ID_W)) dut (
        .Clk(Clk), .Rst(Rst), .i_ext(i_ext), .i_en_wr(i_en_wr),
        .i_en_data(i_en_data), .o_en(o_en), .o_pending(o_pending),
        .o_irq(o_irq), .o_irq_id(o_irq_id), .i_irq_ack(i_irq_ack),
        .i_iret(i_iret)
    );

    always #5 Clk = ~Clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line(s) high for two sampling edges; returns at the negedge after the
    // second sampling edge.
    task automatic pulse(input logic [N_IRQ-1:0] m);
        i_ext = m;
        cyc(2);
        i_ext = '0;
    endtask

    // Accept the current request, then return from the handler.
    task automatic serve();
        i_irq_ack = 1'b1; cyc(1); i_irq_ack = 1'b0;
        i_iret = 1'b1;    cyc(1); i_iret = 1'b0;
    endtask

    initial begin
        Rst = 1'b0; i_ext = '0; i_en_wr = 1'b0; i_en_data = '0;
        i_irq_ack = 1'b0; i_iret = 1'b0;
        cyc(3);
        chk("rst_irq",  32'(o_irq), 32'h0);
        chk("rst_id",   32'(o_irq_id), 32'h0);
        chk("rst_pend", 32'(o_pending), 32'h0);
        chk("rst_en",   32'(o_en), 32'h7FFF_FFFF);
        Rst = 1'b1;
        cyc(2);

        // Single pulse on line 1
        pulse(31'h2);
        chk("sp_pend_early", 32'(o_pending), 32'h0);
        cyc(1);
        chk("sp_pend", 32'(o_pending), 32'h2);
        chk("sp_irq_early", 32'(o_irq), 32'h0);
        cyc(1);
        chk("sp_irq", 32'(o_irq), 32'h1);
        chk("sp_id",  32'(o_irq_id), 32'h1);
        i_irq_ack = 1'b1; cyc(1); i_irq_ack = 1'b0;
        chk("sp_ack_irq",  32'(o_irq), 32'h0);
        chk("sp_ack_pend", 32'(o_pending), 32'h0);
        i_iret = 1'b1; cyc(1); i_iret = 1'b0;
        cyc(3);
        chk("sp_idle_irq", 32'(o_irq), 32'h0);

        // Same line re-pended during service
        pulse(31'h2); cyc(2);
        chk("rp_irq1", 32'(o_irq), 32'h1);
        chk("rp_id1",  32'(o_irq_id), 32'h1);
        i_irq_ack = 1'b1; cyc(1); i_irq_ack = 1'b0;
        chk("rp_ack_pend", 32'(o_pending), 32'h0);
        pulse(31'h2); cyc(1);
        chk("rp_svc_pend", 32'(o_pending), 32'h2);
        chk("rp_svc_irq",  32'(o_irq), 32'h0);
        i_iret = 1'b1; cyc(1); i_iret = 1'b0;
        chk("rp_iret_irq", 32'(o_irq), 32'h0);
        cyc(1);
        chk("rp_irq2", 32'(o_irq), 32'h1);
        chk("rp_id2",  32'(o_irq_id), 32'h1);
        serve(); cyc(3);
        chk("rp_done_irq",  32'(o_irq), 32'h0);
        chk("rp_done_pend", 32'(o_pending), 32'h0);

        // Priority: lines 5 and 2 together
        pulse(31'h24); cyc(1);
        chk("pr_pend", 32'(o_pending), 32'h24);
        cyc(1);
        chk("pr_id_a", 32'(o_irq_id), 32'h2);
        chk("pr_irq_a", 32'(o_irq), 32'h1);
        i_irq_ack = 1'b1; cyc(1); i_irq_ack = 1'b0;
        chk("pr_pend_after", 32'(o_pending), 32'h20);
        i_iret = 1'b1; cyc(1); i_iret = 1'b0;
        cyc(1);
        chk("pr_irq_b", 32'(o_irq), 32'h1);
        chk("pr_id_b",  32'(o_irq_id), 32'h5);
        serve(); cyc(2);

        // Set-wins collision on line 3: second edge reaches pending on the
        // same edge that samples the ack
        pulse(31'h8); cyc(2);
        chk("sw_id", 32'(o_irq_id), 32'h3);
        i_ext = 31'h8; cyc(2); i_ext = '0;
        i_irq_ack = 1'b1; cyc(1); i_irq_ack = 1'b0;
        chk("sw_irq", 32'(o_irq), 32'h0);
        chk("sw_pend", 32'(o_pending), 32'h8);
        i_iret = 1'b1; cyc(1); i_iret = 1'b0;
        cyc(1);
        chk("sw_irq2", 32'(o_irq), 32'h1);
        chk("sw_id2",  32'(o_irq_id), 32'h3);
        serve(); cyc(2);
        chk("sw_done_pend", 32'(o_pending), 32'h0);

        // Masking line 4
        i_en_wr = 1'b1; i_en_data = ALL & ~31'h10; cyc(1); i_en_wr = 1'b0;
        chk("mk_en", 32'(o_en), 32'h7FFF_FFEF);
        pulse(31'h10); cyc(4);
        chk("mk_pend", 32'(o_pending), 32'h10);
        chk("mk_irq",  32'(o_irq), 32'h0);
        i_en_wr = 1'b1; i_en_data = ALL; cyc(1); i_en_wr = 1'b0;
        chk("mk_wr_irq", 32'(o_irq), 32'h0);
        cyc(1);
        chk("mk_irq2", 32'(o_irq), 32'h1);
        chk("mk_id2",  32'(o_irq_id), 32'h4);
        serve(); cyc(2);

        // Reset while in SERVICE with line 7 pending
        pulse(31'h80); cyc(2);
        chk("rs_id", 32'(o_irq_id), 32'h7);
        i_irq_ack = 1'b1; cyc(1); i_irq_ack = 1'b0;
        pulse(31'h80); cyc(1);
        chk("rs_pend_pre", 32'(o_pending), 32'h80);
        i_en_wr = 1'b1; i_en_data = '0; cyc(1); i_en_wr = 1'b0;
        Rst = 1'b0; cyc(1); Rst = 1'b1;
        chk("rs_pend", 32'(o_pending), 32'h0);
        chk("rs_irq",  32'(o_irq), 32'h0);
        chk("rs_en",   32'(o_en), 32'h7FFF_FFFF);
        chk("rs_id0",  32'(o_irq_id), 32'h0);
        cyc(5);
        chk("rs_quiet", 32'(o_irq), 32'h0);
        // FSM must be IDLE: a fresh edge on line 0 yields a request on time
        pulse(31'h1); cyc(1);
        chk("rs_new_early", 32'(o_irq), 32'h0);
        cyc(1);
        chk("rs_new_irq", 32'(o_irq), 32'h1);
        chk("rs_new_id",  32'(o_irq_id), 32'h0);
        serve(); cyc(2);
        chk("end_irq", 32'(o_irq), 32'h0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

External interrupt controller sitting between the SoC's `i_ext` pins and the CPU core's interrupt entry logic. It:

- synchronises up to 31 asynchronous interrupt lines;
- detects rising edges and latches them as pending;
- applies a per-line enable mask;
- presents one prioritised request with a 5-bit vector ID to the core, using an ack/return handshake.

Re-triggering a line while it is in service is captured as a new pending event, never lost.

## Interface

Parameters:
- `N_IRQ`, default 31: number of external interrupt lines.
- `ID_W`, default 5: vector ID width; must satisfy `2**ID_W >= N_IRQ`.

Ports:
- `Clk`  in  1: single clock; all logic is on the rising edge.
- `Rst`  in  1: reset, synchronous, active-low.
- `i_ext`  in  `N_IRQ`: asynchronous interrupt lines, active-high.
- `i_en_wr`  in  1: write strobe for the enable mask.
- `i_en_data`  in  `N_IRQ`: new enable mask (1 = line enabled).
- `o_en`  out  `N_IRQ`: current enable mask.
- `o_pending`  out  `N_IRQ`: current pending register.
- `o_irq`  out  1: interrupt request to the core.
- `o_irq_id`  out  `ID_W`: index of the requested line; valid while `o_irq`=1.
- `i_irq_ack`  in  1: core accepts the request (one-cycle pulse).
- `i_iret`  in  1: core has finished the handler (one-cycle pulse).

## Operation

Reset values (when `Rst`=0 at a clock edge):
- `o_irq`=0, `o_irq_id`=0, `o_pending`=0, `o_en`=all ones.
- Synchroniser and edge-history flops = 0.
- FSM = IDLE.

Input capture:
- Each line passes through a 2-flop synchroniser followed by a history flop.
- Edge condition: synchronised value = 1 and history = 0. It is held for exactly one cycle per rising edge.
- A line must be high for at least one full `Clk` period to be guaranteed captured; shorter pulses may be missed.
- A line held high through reset release counts as one rising edge.

Pending register:
- For each line `k`: `pending[k]` is set by an edge on `k` and cleared by an accepted ack with ID `k`.
- If both happen in the same cycle, set wins and `pending[k]` stays 1.
- Edges are recorded regardless of the enable mask.
- Repeated edges while `pending[k]`=1 coalesce into one pending event.

Enable mask:
- `i_en_wr`=1 loads `i_en_data` into `o_en` at the next edge.
- Masked pending bits stay pending and are not requested.
- Re-enabling a masked line with its pending bit set makes it eligible on the next cycle.

Priority:
- The lowest-index line with `pending & en` = 1 wins.

FSM (registered):
- **IDLE**
  - If any `pending & en` bit is set: latch the winning index into `o_irq_id`, set `o_irq`=1, go to REQ.
  - Otherwise stay in IDLE.
- **REQ**
  - `o_irq`=1 and `o_irq_id` held stable. There is no preemption by higher-priority arrivals, and no withdrawal if the line is masked meanwhile.
  - `i_irq_ack`=1: clear `pending[o_irq_id]` (subject to set-wins), set `o_irq`=0, go to SERVICE.
- **SERVICE**
  - `o_irq`=0.
  - `i_iret`=1: go to IDLE.
  - New edges, including on the in-service line, are latched as pending during this state.

Ignored inputs:
- `i_irq_ack` outside REQ.
- `i_iret` outside SERVICE.
- If both arrive in the same cycle, only the one legal in the current state acts.

## Timing

- Edge-to-request latency:
  - Cycle 0: the rising `Clk` edge first samples `i_ext[k]`=1.
  - Cycle 1: edge condition is true.
  - Cycle 2: `pending[k]`=1.
  - Cycle 3: `o_irq`=1 with `o_irq_id`=k, provided the FSM was IDLE and the line is enabled.
- Ack: `i_irq_ack` sampled at edge t gives `o_irq`=0 and cleared pending bit at edge t.
- Return: `i_iret` sampled at edge t puts the FSM in IDLE at t. If a pending and enabled line exists, `o_irq`=1 at t+1.
- Minimum gap between two serviced interrupts: 1 IDLE cycle.
- Mask write at edge t affects arbitration from edge t+1.
- Reset mid-operation (any state): everything returns to reset values at the same edge, and pending events are discarded.

## Test plan

- **Single pulse:** `i_ext[1]` high for 2 cycles.
  - Require `o_pending[1]`=1, then `o_irq`=1 and `o_irq_id`=1 three cycles after the first sampling edge.
  - Ack → `o_irq`=0 and `o_pending`=0. Iret → IDLE with no further request.
- **Same interrupt re-pended:** pulse `i_ext[1]`, ack, then pulse `i_ext[1]` again during SERVICE.
  - Require `o_pending[1]`=1 during SERVICE.
  - After iret, `o_irq`=1 and `o_irq_id`=1 again one cycle later; exactly two requests in total.
- **Priority:** raise `i_ext[5]` and `i_ext[2]` in the same cycle.
  - Require `o_irq_id`=2 first; after ack and iret, `o_irq_id`=5.
- **Set-wins collision:** an edge on line 3 lands in `pending` in the same cycle `i_irq_ack` is given for ID 3.
  - Require `o_pending[3]` to remain 1 and a second request for ID 3 after iret.
- **Masking:** write `o_en`=0 for line 4, then pulse `i_ext[4]`.
  - Require `o_pending[4]`=1 and `o_irq`=0.
  - Re-enable line 4 → `o_irq`=1 with `o_irq_id`=4.
- **Reset mid-service:** assert `Rst`=0 for one cycle while in SERVICE with `pending[7]`=1.
  - Require `o_pending`=0, `o_irq`=0, `o_en`=all ones, FSM IDLE.
  - No request follows unless a new edge occurs.
